// File: rtl/paddle_pkg.sv
// Shared types and arithmetic helpers for the paddle timer bank.
// Saturating helpers work on a fixed 16-bit carrier; callers pass the live width.
package paddle_pkg;

  typedef enum logic [1:0] {
    MODE_DIGITAL  = 2'd0,
    MODE_ANALOG_Y = 2'd1,
    MODE_ANALOG_X = 2'd2,
    MODE_PADDLE   = 2'd3
  } mode_e;

  localparam int SAT_W = 16;

  // Signed two's complement byte to offset-binary (0x80 -> 0, 0x7F -> 255).
  function automatic logic [7:0] to_unsigned8(input logic [7:0] s);
    return {~s[7], s[6:0]};
  endfunction

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      width);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
    if (sum > lim) return lim[SAT_W-1:0];
    return sum[SAT_W-1:0];
  endfunction

  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    if (a > b) return a - b;
    return '0;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle channel: digital position with acceleration, per-frame pot count
// loaded on vsync and counted down once per line.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int POS_W      = 8,
  parameter int POS_INIT   = 128,
  parameter int SPEED_SLOW = 5,
  parameter int SPEED_FAST = 8,
  parameter int ACCEL_MAX  = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             vs_rise,
  input  logic             hs_rise,
  input  logic             speed_fast,
  input  logic [1:0]       mode,
  input  logic             invert,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic [15:0]      analog,
  input  logic [7:0]       paddle,
  output logic             pot_out,
  output logic [POS_W-1:0] pos
);

  localparam int ACCEL_W = $clog2(ACCEL_MAX + 2);

  mode_e              mode_sel;
  logic [POS_W-1:0]   pos_reg, pos_next;
  logic [POS_W-1:0]   cap_reg, cap_next;
  logic [ACCEL_W-1:0] accel_reg, accel_next;
  logic [7:0]         a8;
  logic [POS_W-1:0]   load_val;
  logic [SAT_W-1:0]   base_step, step, moved;
  logic               up_only, down_only;

  assign mode_sel  = mode_e'(mode);
  assign up_only   = btn_up & ~btn_down;
  assign down_only = btn_down & ~btn_up;

  always_comb begin
    case (mode_sel)
      MODE_ANALOG_Y: a8 = to_unsigned8(analog[15:8]);
      MODE_ANALOG_X: a8 = to_unsigned8(analog[7:0]);
      default:       a8 = paddle;
    endcase
    // Digital mode loads the position held before this frame's move.
    if (mode_sel == MODE_DIGITAL) load_val = pos_reg;
    else                          load_val = POS_W'(a8) << (POS_W - 8);
    load_val = load_val ^ {POS_W{invert}};
  end

  always_comb begin
    base_step = speed_fast ? SAT_W'(SPEED_FAST) : SAT_W'(SPEED_SLOW);
    step      = base_step + SAT_W'(accel_reg);
    if (up_only) moved = sat_sub(SAT_W'(pos_reg), step);
    else         moved = sat_add(SAT_W'(pos_reg), step, POS_W);
  end

  always_comb begin
    pos_next   = pos_reg;
    cap_next   = cap_reg;
    accel_next = accel_reg;
    if (vs_rise) begin
      cap_next = load_val;
      if (mode_sel == MODE_DIGITAL && (up_only || down_only)) begin
        pos_next = POS_W'(moved);
        if (accel_reg < ACCEL_W'(ACCEL_MAX)) accel_next = accel_reg + ACCEL_W'(1);
      end else begin
        accel_next = '0;
      end
    end else if (hs_rise && cap_reg != '0) begin
      cap_next = cap_reg - POS_W'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pos_reg   <= POS_W'(POS_INIT);
      cap_reg   <= '0;
      accel_reg <= '0;
    end else begin
      pos_reg   <= pos_next;
      cap_reg   <= cap_next;
      accel_reg <= accel_next;
    end
  end

  assign pot_out = (cap_reg == '0);
  assign pos     = pos_reg;

endmodule

// File: rtl/paddle_timer_bank.sv
// N-channel paddle/pot-timer emulator: shared sync edge detection feeding
// independent paddle_channel instances.
module paddle_timer_bank
  import paddle_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int POS_W      = 8,
  parameter int POS_INIT   = 128,
  parameter int SPEED_SLOW = 5,
  parameter int SPEED_FAST = 8,
  parameter int ACCEL_MAX  = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    hs,
  input  logic                    vs,
  input  logic                    speed_fast,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       invert,
  input  logic [NUM_CH-1:0]       btn_up,
  input  logic [NUM_CH-1:0]       btn_down,
  input  logic [16*NUM_CH-1:0]    analog,
  input  logic [8*NUM_CH-1:0]     paddle,
  output logic [NUM_CH-1:0]       pot_out,
  output logic [POS_W*NUM_CH-1:0] pos
);

  logic hs_d_reg, vs_d_reg;
  logic vs_rise, hs_rise;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_d_reg <= 1'b0;
      vs_d_reg <= 1'b0;
    end else begin
      hs_d_reg <= hs;
      vs_d_reg <= vs;
    end
  end

  // A frame load takes priority over a line decrement in the same cycle.
  assign vs_rise = vs & ~vs_d_reg;
  assign hs_rise = hs & ~hs_d_reg & ~vs_rise;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      paddle_channel #(
        .POS_W      (POS_W),
        .POS_INIT   (POS_INIT),
        .SPEED_SLOW (SPEED_SLOW),
        .SPEED_FAST (SPEED_FAST),
        .ACCEL_MAX  (ACCEL_MAX)
      ) u_channel (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .vs_rise    (vs_rise),
        .hs_rise    (hs_rise),
        .speed_fast (speed_fast),
        .mode       (mode[2*gi +: 2]),
        .invert     (invert[gi]),
        .btn_up     (btn_up[gi]),
        .btn_down   (btn_down[gi]),
        .analog     (analog[16*gi +: 16]),
        .paddle     (paddle[8*gi +: 8]),
        .pot_out    (pot_out[gi]),
        .pos        (pos[POS_W*gi +: POS_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_paddle_timer_bank.sv
// Bench for paddle_timer_bank: an 8-bit two-channel bank and a 10-bit one-channel
// bank share sync and reset; a frame-level model is compared every cycle.
module tb_paddle_timer_bank;

  logic        clk_sys = 1'b0;
  logic        reset, hs, vs, speed_fast;
  logic [3:0]  mode_a;
  logic [1:0]  invert_a, up_a, down_a, pot_a;
  logic [31:0] analog_a;
  logic [15:0] paddle_a, pos_a;
  logic [1:0]  mode_b;
  logic        invert_b, up_b, down_b, pot_b;
  logic [15:0] analog_b;
  logic [7:0]  paddle_b;
  logic [9:0]  pos_b;

  int checks = 0;
  int failures = 0;

  int m_pos[3], m_cap[3], m_acc[3];
  bit m_hs_d, m_vs_d;

  typedef struct {
    logic [1:0]  md;
    logic        inv;
    logic [15:0] an;
    logic [7:0]  pd;
    int          exp8;
    int          exp10;
  } vec_t;
  vec_t vecs[8];

  always #5 clk_sys = ~clk_sys;

  paddle_timer_bank #(.NUM_CH(2), .POS_W(8), .POS_INIT(128), .SPEED_SLOW(5),
                      .SPEED_FAST(8), .ACCEL_MAX(4)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .speed_fast(speed_fast),
    .mode(mode_a), .invert(invert_a), .btn_up(up_a), .btn_down(down_a),
    .analog(analog_a), .paddle(paddle_a), .pot_out(pot_a), .pos(pos_a));

  paddle_timer_bank #(.NUM_CH(1), .POS_W(10), .POS_INIT(128), .SPEED_SLOW(5),
                      .SPEED_FAST(8), .ACCEL_MAX(4)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .speed_fast(speed_fast),
    .mode(mode_b), .invert(invert_b), .btn_up(up_b), .btn_down(down_b),
    .analog(analog_b), .paddle(paddle_b), .pot_out(pot_b), .pos(pos_b));

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_pos[ch] = 128;
      m_cap[ch] = 0;
      m_acc[ch] = 0;
    end
    m_hs_d = 0;
    m_vs_d = 0;
  endtask

  // One clock edge of the frame-level behaviour, from the inputs present at the edge.
  task automatic model_edge();
    bit vr, hr;
    int w, maxv, md, a, load, step;
    bit inv, up, dn;
    logic [7:0] yb, xb, pd;
    vr = vs && !m_vs_d;
    hr = hs && !m_hs_d && !vr;
    m_vs_d = vs;
    m_hs_d = hs;
    for (int ch = 0; ch < 3; ch++) begin
      if (ch < 2) begin
        w = 8; md = int'(mode_a[2*ch +: 2]); inv = invert_a[ch];
        up = up_a[ch]; dn = down_a[ch];
        yb = analog_a[16*ch+8 +: 8]; xb = analog_a[16*ch +: 8]; pd = paddle_a[8*ch +: 8];
      end else begin
        w = 10; md = int'(mode_b); inv = invert_b; up = up_b; dn = down_b;
        yb = analog_b[15:8]; xb = analog_b[7:0]; pd = paddle_b;
      end
      maxv = (1 << w) - 1;
      if (vr) begin
        case (md)
          0:       a = 0;
          1:       a = int'($signed(yb)) + 128;
          2:       a = int'($signed(xb)) + 128;
          default: a = int'(pd);
        endcase
        load = (md == 0) ? m_pos[ch] : a * (1 << (w - 8));
        if (inv) load = maxv - load;
        m_cap[ch] = load;
        if (md == 0 && (up != dn)) begin
          step = (speed_fast ? 8 : 5) + m_acc[ch];
          if (up) m_pos[ch] = (m_pos[ch] - step < 0) ? 0 : m_pos[ch] - step;
          else    m_pos[ch] = (m_pos[ch] + step > maxv) ? maxv : m_pos[ch] + step;
          m_acc[ch] = (m_acc[ch] + 1 > 4) ? 4 : m_acc[ch] + 1;
        end else begin
          m_acc[ch] = 0;
        end
      end else if (hr && m_cap[ch] > 0) begin
        m_cap[ch] = m_cap[ch] - 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("pot_a%0d", ch), int'(pot_a[ch]), int'(m_cap[ch] == 0));
      check($sformatf("pos_a%0d", ch), int'(pos_a[8*ch +: 8]), m_pos[ch]);
    end
    check("pot_b0", int'(pot_b), int'(m_cap[2] == 0));
    check("pos_b0", int'(pos_b), m_pos[2]);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (reset) model_reset();
    else       model_edge();
    #1;
    compare_all();
  endtask

  task automatic frame(input int lines);
    vs = 1'b1; tick();
    vs = 1'b0; tick();
    for (int i = 0; i < lines; i++) begin
      hs = 1'b1; tick();
      hs = 1'b0; tick();
    end
  endtask

  // Counts line pulses until pot_a[1] and pot_b go high; -1 if never within the bound.
  task automatic measure(output int na, output int nb);
    int n;
    na = pot_a[1] ? 0 : -1;
    nb = pot_b ? 0 : -1;
    n = 0;
    while ((na < 0 || nb < 0) && n < 1100) begin
      hs = 1'b1; tick();
      n++;
      if (na < 0 && pot_a[1]) na = n;
      if (nb < 0 && pot_b) nb = n;
      hs = 1'b0; tick();
    end
  endtask

  initial begin
    int na, nb;
    int exp_up[4];
    exp_up[0] = 123; exp_up[1] = 117; exp_up[2] = 110; exp_up[3] = 102;
    vecs[0] = '{2'd1, 1'b0, 16'h8000, 8'd0,   0,    0};
    vecs[1] = '{2'd1, 1'b0, 16'h7F00, 8'd0,   255,  1020};
    vecs[2] = '{2'd1, 1'b1, 16'h0000, 8'd0,   127,  511};
    vecs[3] = '{2'd1, 1'b0, 16'h0000, 8'd0,   128,  512};
    vecs[4] = '{2'd2, 1'b0, 16'h7F81, 8'd0,   1,    4};
    vecs[5] = '{2'd3, 1'b0, 16'h0000, 8'd200, 200,  800};
    vecs[6] = '{2'd3, 1'b1, 16'h0000, 8'd200, 55,   223};
    vecs[7] = '{2'd2, 1'b1, 16'h0080, 8'd0,   255,  1023};

    reset = 1'b1; hs = 0; vs = 0; speed_fast = 0;
    mode_a = 0; invert_a = 0; up_a = 0; down_a = 0; analog_a = 0; paddle_a = 0;
    mode_b = 0; invert_b = 0; up_b = 0; down_b = 0; analog_b = 0; paddle_b = 0;
    #1;
    model_reset();
    check("reset_pot_a", int'(pot_a), 3);
    check("reset_pos_a", int'(pos_a), (128 << 8) | 128);
    check("reset_pot_b", int'(pot_b), 1);
    tick(); tick();
    reset = 1'b0;

    // First frame in digital mode loads 128 and counts down one per line.
    vs = 1'b1; tick();
    check("first_load_pot", int'(pot_a), 0);
    vs = 1'b0; tick();
    measure(na, nb);
    check("first_frame_lines_a", na, 128);
    check("first_frame_lines_b", nb, 128);
    $display("seq first_frame lines_a=%0d lines_b=%0d", na, nb);

    // Acceleration while held, reset of acceleration after release.
    up_a = 2'b01;
    for (int i = 0; i < 4; i++) begin
      frame(0);
      check($sformatf("accel_frame%0d", i), int'(pos_a[7:0]), exp_up[i]);
    end
    up_a = 2'b00; frame(0);
    check("release_hold", int'(pos_a[7:0]), 102);
    up_a = 2'b01; frame(0);
    check("restart_step", int'(pos_a[7:0]), 97);
    $display("seq accel pos=%0d", pos_a[7:0]);

    // Saturation at both ends, both-pressed cancel.
    repeat (20) frame(0);
    check("sat_low", int'(pos_a[7:0]), 0);
    up_a = 2'b00; down_a = 2'b01; speed_fast = 1'b1;
    repeat (40) frame(0);
    check("sat_high", int'(pos_a[7:0]), 255);
    up_a = 2'b01; frame(0);
    check("both_held", int'(pos_a[7:0]), 255);
    down_a = 2'b00; frame(0);
    check("after_both_step", int'(pos_a[7:0]), 247);
    up_a = 2'b00;
    $display("seq saturation pos=%0d", pos_a[7:0]);

    // Load value tables for the non-digital modes at both widths.
    for (int v = 0; v < 8; v++) begin
      mode_a[3:2] = vecs[v].md; invert_a[1] = vecs[v].inv;
      analog_a[31:16] = vecs[v].an; paddle_a[15:8] = vecs[v].pd;
      mode_b = vecs[v].md; invert_b = vecs[v].inv;
      analog_b = vecs[v].an; paddle_b = vecs[v].pd;
      frame(0);
      measure(na, nb);
      check($sformatf("vec%0d_cap8", v), na, vecs[v].exp8);
      check($sformatf("vec%0d_cap10", v), nb, vecs[v].exp10);
      $display("vec %0d mode=%0d inv=%0d cap8=%0d cap10=%0d", v, vecs[v].md, vecs[v].inv, na, nb);
    end

    // Coincident hs/vs: load wins, no decrement.
    invert_a = 0; invert_b = 0;
    mode_a[3:2] = 2'd3; paddle_a[15:8] = 8'd10; mode_b = 2'd3; paddle_b = 8'd10;
    hs = 1'b1; vs = 1'b1; tick();
    hs = 1'b0; vs = 1'b0; tick();
    measure(na, nb);
    check("coincident_a", na, 10);
    check("coincident_b", nb, 40);
    $display("seq coincident lines_a=%0d lines_b=%0d", na, nb);

    // Countdown holds at zero.
    paddle_a[15:8] = 8'd255; paddle_b = 8'd255;
    frame(300);
    check("no_underflow_a", int'(pot_a[1]), 1);
    check("partial_b", int'(pot_b), 0);
    $display("seq underflow pot_a1=%0d pot_b=%0d", pot_a[1], pot_b);

    // Asynchronous reset mid-frame.
    speed_fast = 1'b0; paddle_a[15:8] = 8'd40; up_a = 2'b01;
    repeat (3) frame(0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_pot_a", int'(pot_a), 3);
    check("async_reset_pos_a", int'(pos_a), (128 << 8) | 128);
    check("async_reset_pot_b", int'(pot_b), 1);
    tick();
    reset = 1'b0;
    frame(0);
    check("post_reset_step", int'(pos_a[7:0]), 123);
    up_a = 2'b00;
    $display("seq async_reset pos=%0d", pos_a[7:0]);

    // Randomised frames against the model.
    for (int f = 0; f < 30; f++) begin
      mode_a = 4'($urandom); invert_a = 2'($urandom); up_a = 2'($urandom);
      down_a = 2'($urandom); analog_a = $urandom; paddle_a = 16'($urandom);
      mode_b = 2'($urandom); invert_b = 1'($urandom); up_b = 1'($urandom);
      down_b = 1'($urandom); analog_b = 16'($urandom); paddle_b = 8'($urandom);
      speed_fast = 1'($urandom);
      vs = 1'b1; hs = 1'($urandom); tick();
      for (int c = 0; c < int'($urandom_range(20, 300)); c++) begin
        vs = ($urandom_range(0, 99) == 0);
        hs = 1'($urandom);
        tick();
      end
      vs = 1'b0;
      $display("rand frame %0d pos_a=%0d/%0d pos_b=%0d", f, pos_a[7:0], pos_a[15:8], pos_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
